// File: rtl/elastic_buffer_sync_if.sv
// Symbol/handshake bundle for elastic_buffer_sync; the buffer binds to the slave modport.
interface elastic_buffer_sync_if #(
  parameter int unsigned DATA_WIDTH   = 10,
  parameter int unsigned BUFFER_DEPTH = 16
);
  localparam int unsigned LW = $clog2(BUFFER_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  full;
  logic                  empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;
  logic                  skp_added;
  logic                  skp_dropped;

  modport master (
    output data_in, wr_en, rd_en, clr_err,
    input  data_out, data_valid, full, empty, level,
           overflow, underflow, skp_added, skp_dropped
  );

  modport slave (
    input  data_in, wr_en, rd_en, clr_err,
    output data_out, data_valid, full, empty, level,
           overflow, underflow, skp_added, skp_dropped
  );
endinterface

// File: rtl/elastic_buffer_sync.sv
// Single-clock elastic buffer with sticky over/underflow flags.
// Define ELASTIC_SKP_COMP_EN to compile in SKP drop/insert clock compensation.
module elastic_buffer_sync #(
  parameter int unsigned          DATA_WIDTH   = 10,
  parameter int unsigned          BUFFER_DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] SKP_SYMBOL  = 10'h21C,
  parameter int unsigned          LOW_WM       = 4,
  parameter int unsigned          HIGH_WM      = 12
) (
  input logic                  clk,
  input logic                  rst_n,
  elastic_buffer_sync_if.slave bus
);
  localparam int unsigned AW = $clog2(BUFFER_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(BUFFER_DEPTH);
  localparam logic [LW-1:0] LOW_L   = LW'(LOW_WM);
  localparam logic [LW-1:0] HIGH_L  = LW'(HIGH_WM);

`ifdef ELASTIC_SKP_COMP_EN
  localparam bit SKP_COMP = 1'b1;
`else
  localparam bit SKP_COMP = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q, overflow_q, underflow_q;
  logic                  skp_added_q, skp_dropped_q;

  logic full_w, empty_w, drop, ins, wr_ok, rd_ok;

  always_comb begin
    full_w  = (level_q == DEPTH_L);
    empty_w = (level_q == '0);
    drop    = SKP_COMP && bus.wr_en && (bus.data_in == SKP_SYMBOL) &&
              (level_q > HIGH_L) && !full_w;
    // Insert replays the head SKP without consuming it, so the reader gains a symbol.
    ins     = SKP_COMP && bus.rd_en && (level_q < LOW_L) && !empty_w &&
              (mem[rd_ptr] == SKP_SYMBOL);
    wr_ok   = bus.wr_en && !full_w && !drop;
    rd_ok   = bus.rd_en && !empty_w && !ins;
  end

  // Storage is intentionally unreset; occupancy tracking guards against stale reads.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      skp_added_q   <= 1'b0;
      skp_dropped_q <= 1'b0;
    end else begin
      data_valid_q  <= 1'b0;
      skp_added_q   <= ins;
      skp_dropped_q <= drop;

      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;

      if (rd_ok) begin
        rd_ptr       <= rd_ptr + 1'b1;
        data_out_q   <= mem[rd_ptr];
        data_valid_q <= 1'b1;
      end else if (ins) begin
        data_out_q   <= SKP_SYMBOL;
        data_valid_q <= 1'b1;
      end

      if (wr_ok && !rd_ok)      level_q <= level_q + 1'b1;
      else if (!wr_ok && rd_ok) level_q <= level_q - 1'b1;

      if (bus.wr_en && full_w)  overflow_q <= 1'b1;
      else if (bus.clr_err)     overflow_q <= 1'b0;

      if (bus.rd_en && empty_w) underflow_q <= 1'b1;
      else if (bus.clr_err)     underflow_q <= 1'b0;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.level       = level_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.skp_added   = skp_added_q;
  assign bus.skp_dropped = skp_dropped_q;
endmodule

// File: doc/elastic_buffer_sync.md
ELASTIC_BUFFER_SYNC -- requirements
Module: elastic_buffer_sync

Interface
REQ-001 Parameter DATA_WIDTH, default 10, symbol width; bit DATA_WIDTH-1 is the K flag.
REQ-002 Parameter BUFFER_DEPTH, default 16, entry count; power of 2, minimum 4.
REQ-003 Parameter SKP_SYMBOL, default 10'h21C (K flag set, K28.0), skip symbol used for compensation.
REQ-004 Parameter LOW_WM, default 4, underflow-risk watermark; LOW_WM SHALL be less than HIGH_WM.
REQ-005 Parameter HIGH_WM, default 12, overflow-risk watermark; HIGH_WM SHALL be less than BUFFER_DEPTH.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 data_in  input  DATA_WIDTH  write symbol.
REQ-009 wr_en  input  1  write request.
REQ-010 rd_en  input  1  read request.
REQ-011 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-012 data_out  output  DATA_WIDTH  registered read symbol.
REQ-013 data_valid  output  1  data_out updated this cycle.
REQ-014 full, empty  output  1 each  level==BUFFER_DEPTH, level==0.
REQ-015 level  output  $clog2(BUFFER_DEPTH)+1  current occupancy.
REQ-016 overflow, underflow  output  1 each  sticky error flags.
REQ-017 skp_added, skp_dropped  output  1 each  one-cycle compensation pulses.

Function
REQ-018 Accepted write: wr_en=1, full=0, not dropped; stores data_in at write pointer, pointer increments mod BUFFER_DEPTH.
REQ-019 Accepted read: rd_en=1, empty=0; data_out = entry at read pointer, data_valid=1 on the following cycle (1-cycle latency), pointer increments mod BUFFER_DEPTH.
REQ-020 Cycles without an accepted read or inserted SKP: data_valid=0, data_out holds its value.
REQ-021 level: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither; never wraps.
REQ-022 full/empty use start-of-cycle level; a write while full is rejected even with a simultaneous read.
REQ-023 Write while full: data discarded, pointers/level unchanged, overflow set.
REQ-024 Read while empty: data_out held, data_valid=0, underflow set.
REQ-025 overflow/underflow remain set until clr_err=1 or reset; a same-cycle new error has priority over clr_err.
REQ-026 Write and read pointers are independent; simultaneous read and write of the same entry returns the old content.

Reset
REQ-027 rst_n=0 asynchronously clears pointers, level, data_out, data_valid, overflow, underflow, skp_added, skp_dropped; full=0, empty=1.
REQ-028 Reset mid-operation discards all stored symbols; storage array is not reset and is unreadable until rewritten.
REQ-029 First write is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro ELASTIC_SKP_COMP_EN compiles in skip compensation; without it, SKP_SYMBOL is treated as ordinary data and skp_added/skp_dropped are tied 0.
REQ-031 With macro, drop: wr_en=1, data_in==SKP_SYMBOL, level>HIGH_WM, full=0: symbol not stored, level unchanged, skp_dropped=1 next cycle.
REQ-032 With macro, insert: rd_en=1, level<LOW_WM, level>0, head entry==SKP_SYMBOL: data_out=SKP_SYMBOL, data_valid=1, read pointer and level unchanged, skp_added=1 next cycle.
REQ-033 With macro, a write concurrent with an insert is processed normally; drop and insert cannot coincide since LOW_WM<HIGH_WM.

Verification
REQ-034 Reset, write 16 symbols 0x001..0x010, no reads -> full=1, level=16; 17th write -> overflow=1, level stays 16.
REQ-035 Read 16 after REQ-034 fill -> data_out 0x001..0x010 in order, each 1 cycle after rd_en; then read -> underflow=1, data_valid=0.
REQ-036 Simultaneous wr_en/rd_en for 40 cycles at level 8 -> level stays 8, pointers wrap, data order preserved.
REQ-037 Macro on, level=13, write 0x21C -> skp_dropped pulse, level stays 13; macro off -> level 14.
REQ-038 Macro on, level=2, head=0x21C, rd_en -> data_out=0x21C, skp_added pulse, level 2; next read returns 0x21C again.
REQ-039 Assert rst_n=0 mid-burst at level 9 -> level=0, empty=1, data_valid=0 immediately, flags cleared.
